// File: rtl/fetch.sv
// fetch: IF stage -- owns the PC, issues word fetches, buffers responses in order, squashes on redirect.
// Optional perf counters (perf_fetched/perf_bubbles) exist only when FETCH_PERF_CNT_EN is defined.
package fetch_pkg;
   typedef struct packed {
      logic [31:0] instruction_value;
      logic [31:0] pc_value;
      logic        pc_r;
   } fe_to_de_s;
endpackage

module fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles,
`endif
   output fe_to_de_s   fe_to_de
);

   localparam int unsigned PW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = CW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] disc_q, disc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   buf_instr_q [BUF_DEPTH];
   logic [31:0]   buf_pc_q    [BUF_DEPTH];
   fe_to_de_s     out_q, out_d;
   logic          req_fire, rsp_ok, push, pop;
   logic          unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   // Credits: every accepted request already owns a buffer slot.
   assign imem_req_valid = rst_n && !redirect_valid &&
                           ((SW'(outst_q) + SW'(count_q)) < SW'(BUF_DEPTH));
   assign imem_req_addr  = pc_q;
   assign fe_to_de       = out_q;

   // Next-state: request issue, response retire/discard, buffer pop, redirect flush.
   always_comb begin
      req_fire = imem_req_valid && imem_req_ready;
      rsp_ok   = imem_rsp_valid && (outst_q != '0);
      push     = rsp_ok && (disc_q == '0) && !redirect_valid;
      pop      = en && (count_q != '0) && !redirect_valid;
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      outst_d  = outst_q;
      disc_d   = disc_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      out_d    = out_q;
      if (redirect_valid) begin
         pc_d       = {redirect_pc[31:2], 2'b00};
         rsp_pc_d   = {redirect_pc[31:2], 2'b00};
         outst_d    = outst_q - CW'(rsp_ok);
         disc_d     = outst_q - CW'(rsp_ok);
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         out_d.pc_r = 1'b1;
      end else begin
         if (req_fire) pc_d = pc_q + 32'd4;
         outst_d = outst_q + CW'(req_fire) - CW'(rsp_ok);
         if (rsp_ok && (disc_q != '0)) disc_d = disc_q - CW'(1);
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rsp_pc_d = rsp_pc_q + 32'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
         if (en) begin
            if (count_q != '0) begin
               out_d.instruction_value = buf_instr_q[rd_ptr_q];
               out_d.pc_value          = buf_pc_q[rd_ptr_q];
               out_d.pc_r              = 1'b0;
            end else begin
               out_d.pc_r = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         disc_q   <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         out_q    <= '{instruction_value: NOP, pc_value: 32'h0, pc_r: 1'b1};
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         disc_q   <= disc_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         out_q    <= out_d;
      end
   end

   // Buffer payload needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr_q[wr_ptr_q] <= imem_rsp_data;
         buf_pc_q[wr_ptr_q]    <= rsp_pc_q;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetched_q, bubbles_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_q <= '0;
         bubbles_q <= '0;
      end else if (en) begin
         if (out_d.pc_r) begin
            if (bubbles_q != '1) bubbles_q <= bubbles_q + 32'd1;
         end else if (fetched_q != '1) begin
            fetched_q <= fetched_q + 32'd1;
         end
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: table vectors, hand-written corner sequences and random traffic against a queue-based model.
// Build with FETCH_PERF_CNT_EN defined to also check the perf counters.
module tb_fetch;
   import fetch_pkg::*;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n, en, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data;
   fe_to_de_s   fe_to_de;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_bubbles;
`endif

   fetch #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetched   (perf_fetched),
      .perf_bubbles   (perf_bubbles),
`endif
      .fe_to_de       (fe_to_de)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   typedef struct {
      logic        en;
      logic        rdy;
      logic        exp_valid;
      logic [31:0] exp_addr;
      logic        exp_pc_r;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;

   req_t        inflight[$];
   ent_t        bufq[$];
   logic [31:0] dut_fired_q[$];
   fe_to_de_s   exp_out;
   logic [31:0] exp_pc, m_fetched, m_bubbles;
   int          epoch = 0, cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
   int          n_checks = 0, n_fail = 0;
   vec_t        vecs[8];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0F01;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_out();
      chk("pc_r", 32'(fe_to_de.pc_r), 32'(exp_out.pc_r));
      chk("pc_value", fe_to_de.pc_value, exp_out.pc_value);
      chk("instr", fe_to_de.instruction_value, exp_out.instruction_value);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      inflight.delete(); bufq.delete(); epoch++;
      exp_out.instruction_value = NOP; exp_out.pc_value = '0; exp_out.pc_r = 1'b1;
      exp_pc = 32'h0; m_fetched = '0; m_bubbles = '0; last_due = 0;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk_out();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // One clock: drive at posedge+1, check request side, step model, check fe_to_de after the edge.
   task automatic cycle(input logic en_v, input logic rdy_v, input logic redir_v,
                        input logic [31:0] redir_pc, output logic s_valid, output logic [31:0] s_addr);
      logic rsp_v, exp_valid, kept;
      req_t r;
      ent_t e;
      int   due;
      en = en_v; imem_req_ready = rdy_v; redirect_valid = redir_v; redirect_pc = redir_pc;
      rsp_v = (inflight.size() != 0) && (inflight[0].due <= cyc);
      imem_rsp_valid = rsp_v;
      imem_rsp_data  = rsp_v ? mem_word(inflight[0].addr) : $urandom();
      #1;
      s_valid = imem_req_valid; s_addr = imem_req_addr;
      exp_valid = !redir_v && ((inflight.size() + bufq.size()) < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_valid));
      if (exp_valid) chk("req_addr", imem_req_addr, exp_pc);
      if (imem_req_valid && rdy_v) dut_fired_q.push_back(imem_req_addr);
      kept = 1'b0;
      if (rsp_v) begin
         r = inflight.pop_front();
         kept = (r.epoch == epoch) && !redir_v;
      end
      if (redir_v) begin
         exp_out.pc_r = 1'b1;
         bufq.delete();
         epoch++;
         exp_pc = {redir_pc[31:2], 2'b00};
      end else if (en_v) begin
         if (bufq.size() != 0) begin
            e = bufq.pop_front();
            exp_out.instruction_value = e.instr; exp_out.pc_value = e.pc; exp_out.pc_r = 1'b0;
         end else begin
            exp_out.pc_r = 1'b1;
         end
      end
      if (en_v) begin
         if (exp_out.pc_r) begin if (m_bubbles != '1) m_bubbles++; end
         else if (m_fetched != '1) m_fetched++;
      end
      if (kept) bufq.push_back('{pc: r.addr, instr: mem_word(r.addr)});
      if (exp_valid && rdy_v) begin
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         inflight.push_back('{addr: exp_pc, epoch: epoch, due: due});
         exp_pc = exp_pc + 32'd4;
      end
      cyc++;
      @(posedge clk); #1;
      chk_out();
   endtask

   initial begin
      logic        sv, found;
      logic [31:0] sa, held;
      // Reset, 1-cycle imem, en=1: hand-derived start-up stream.
      vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b1, 32'h0,  NOP};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0,  NOP};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  mem_word(32'h0)};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b0, 32'h4,  mem_word(32'h4)};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4,  mem_word(32'h4)};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h8,  mem_word(32'h8)};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'hC,  mem_word(32'hC)};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC,  mem_word(32'hC)};

      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].en, vecs[i].rdy, 1'b0, 32'h0, sv, sa);
         chk("tbl_valid", 32'(sv), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) chk("tbl_addr", sa, vecs[i].exp_addr);
         chk("tbl_pc_r", 32'(fe_to_de.pc_r), 32'(vecs[i].exp_pc_r));
         chk("tbl_pc", fe_to_de.pc_value, vecs[i].exp_pc);
         chk("tbl_instr", fe_to_de.instruction_value, vecs[i].exp_instr);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("tbl_perf_fetched", perf_fetched, 32'd4);
      chk("tbl_perf_bubbles", perf_bubbles, 32'd4);
`endif

      // imem stall for 5 cycles: request address held, stream resumes there.
      do_reset();
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, sv, sa);
      held = exp_pc;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 32'h0, sv, sa);
         chk("stall_addr", imem_req_addr, held);
      end
      dut_fired_q.delete();
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, sv, sa);
      chk("resume_any", 32'(dut_fired_q.size() != 0), 32'd1);
      if (dut_fired_q.size() != 0) chk("resume_addr", dut_fired_q[0], held);

      // Decode stalled 10 cycles, then continues.
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, sv, sa);
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, sv, sa);

      // 3-cycle imem, two outstanding, redirect coincides with the first response.
      do_reset();
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, sv, sa);
      cycle(1'b1, 1'b1, 1'b1, 32'h100, sv, sa);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0, sv, sa);
         if (!fe_to_de.pc_r) found = 1'b1;
      end
      chk("redir_found", 32'(found), 32'd1);
      if (found) chk("redir_first_pc", fe_to_de.pc_value, 32'h100);

      // Unaligned redirect target and PC wrap.
      lat_min = 1; lat_max = 1;
      cycle(1'b1, 1'b1, 1'b1, 32'h203, sv, sa);
      chk("redir_align", imem_req_addr, 32'h200);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, sv, sa);
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, sv, sa);
      dut_fired_q.delete();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, sv, sa);
      chk("wrap_n", 32'(dut_fired_q.size() >= 3), 32'd1);
      if (dut_fired_q.size() >= 3) begin
         chk("wrap_a0", dut_fired_q[0], 32'hFFFF_FFF8);
         chk("wrap_a1", dut_fired_q[1], 32'hFFFF_FFFC);
         chk("wrap_a2", dut_fired_q[2], 32'h0000_0000);
      end

      // Random traffic with variable latency, redirects and one mid-run reset.
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) do_reset();
         cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0),
               1'($urandom_range(31, 0) == 0),
               ($urandom_range(1, 0) != 0) ? $urandom() : (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))),
               sv, sa);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
      $fatal(1);
   end

endmodule
